bit_stream_serializer: RTL and testbench



---
 rtl/bit_stream_serializer.sv | 115 +++++++++++
 tb/tb_bit_stream_serializer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial word source with a one-entry holding buffer and programmable bit period.
// Define SER_LSB_FIRST_EN to shift words out LSB-first instead of MSB-first.
module bit_stream_serializer #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DIV_W-1:0]  bit_div,
  output logic              dout_bit,
  output logic              bit_stb,
  output logic              busy,
  output logic              frame_done
);

  localparam int IDX_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;

  state_t             state, state_nxt;
  logic               hold_full;
  logic [DATA_W-1:0]  hold_data, shreg;
  logic [DIV_W-1:0]   div_q, cnt;
  logic [IDX_W-1:0]   bit_idx;
  logic               bit_end, last_bit, load;
  logic               first_bit, next_bit;
  logic [DATA_W-1:0]  load_rest, shreg_adv;

  assign tx_ready = !hold_full;
  assign bit_end  = (cnt == div_q);
  assign last_bit = bit_end && (bit_idx == IDX_W'(DATA_W - 1));
  // The shifter takes the buffered word from IDLE or at the end of the last bit (gapless reload).
  assign load     = hold_full && ((state == IDLE) || ((state == SHIFT) && last_bit));

`ifdef SER_LSB_FIRST_EN
  assign first_bit = hold_data[0];
  assign load_rest = hold_data >> 1;
  assign next_bit  = shreg[0];
  assign shreg_adv = shreg >> 1;
`else
  assign first_bit = hold_data[DATA_W-1];
  assign load_rest = hold_data << 1;
  assign next_bit  = shreg[DATA_W-1];
  assign shreg_adv = shreg << 1;
`endif

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = hold_full ? SHIFT : IDLE;
      SHIFT:   state_nxt = (last_bit && !hold_full) ? IDLE : SHIFT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (tx_valid && !hold_full) begin
      hold_full <= 1'b1;
      hold_data <= tx_data;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      shreg      <= '0;
      div_q      <= '0;
      cnt        <= '0;
      bit_idx    <= '0;
      dout_bit   <= 1'b0;
      bit_stb    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      bit_stb    <= 1'b0;
      frame_done <= (state == SHIFT) && last_bit;
      busy       <= (state_nxt != IDLE);
      if (load) begin
        shreg    <= load_rest;
        div_q    <= bit_div;
        cnt      <= '0;
        bit_idx  <= '0;
        dout_bit <= first_bit;
        bit_stb  <= 1'b1;
      end else if (state == SHIFT) begin
        if (last_bit) begin
          dout_bit <= 1'b0;
        end else if (bit_end) begin
          cnt      <= '0;
          bit_idx  <= bit_idx + 1'b1;
          dout_bit <= next_bit;
          shreg    <= shreg_adv;
          bit_stb  <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        dout_bit <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Randomized bench for bit_stream_serializer against a cycle-count based word-timeline model.
module tb_bit_stream_serializer;
  localparam int DW = 8;
  localparam int VW = 16;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [VW-1:0] bit_div;
  logic          dout_bit, bit_stb, busy, frame_done;

  int n_vec = 0;
  int n_err = 0;

  bit_stream_serializer #(.DATA_W(DW), .DIV_W(VW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .bit_div(bit_div), .dout_bit(dout_bit), .bit_stb(bit_stb),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk_in = ~clk_in;

  // Model: a word loaded at time t with period p=div+1 owns cycles t..t+DW*p-1.
  logic          m_active, m_hold_full, m_fd;
  logic [DW-1:0] m_word, m_hold_word;
  int            m_div, m_elapsed;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic word_bit(input logic [DW-1:0] w, input int idx);
`ifdef SER_LSB_FIRST_EN
    return w[idx];
`else
    return w[DW-1-idx];
`endif
  endfunction

  task automatic check_outputs();
    int p;
    p = m_div + 1;
    chk("busy", busy, m_active);
    chk("dout_bit", dout_bit, m_active ? word_bit(m_word, m_elapsed / p) : 1'b0);
    chk("bit_stb", bit_stb, m_active && (m_elapsed % p == 0));
    chk("frame_done", frame_done, m_fd);
    chk("tx_ready", tx_ready, !m_hold_full);
  endtask

  function automatic void mdl_reset();
    m_active = 0; m_hold_full = 0; m_fd = 0;
    m_word = '0; m_hold_word = '0; m_div = 0; m_elapsed = 0;
  endfunction

  function automatic void mdl_edge(input logic v, input logic [DW-1:0] d, input logic [VW-1:0] dv);
    logic old_hold;
    old_hold = m_hold_full;
    m_fd = 0;
    if (m_active) begin
      if (m_elapsed + 1 == DW * (m_div + 1)) begin
        m_fd = 1;
        m_active = 0;
      end else m_elapsed++;
    end
    if (!m_active && old_hold) begin
      m_active = 1; m_word = m_hold_word; m_div = int'(dv); m_elapsed = 0; m_hold_full = 0;
    end
    if (v && !old_hold) begin
      m_hold_full = 1; m_hold_word = d;
    end
  endfunction

  task automatic step(input logic v, input logic [DW-1:0] d, input logic [VW-1:0] dv);
    @(negedge clk_in);
    check_outputs();
    tx_valid = v; tx_data = d; bit_div = dv;
    mdl_edge(v, d, dv);
  endtask

  // Asynchronous reset pulse away from the clock edge; outputs must clear at once.
  task automatic pulse_reset(input logic [VW-1:0] dv);
    @(negedge clk_in);
    rst_n_in = 1'b0;
    #1;
    mdl_reset();
    check_outputs();
    #1;
    rst_n_in = 1'b1;
    tx_valid = 1'b0; bit_div = dv;
    mdl_edge(1'b0, tx_data, dv);
  endtask

  initial begin
    logic [VW-1:0] dv;
    rst_n_in = 1'b0; tx_valid = 1'b0; tx_data = '0; bit_div = '0;
    mdl_reset();
    #3;
    check_outputs();
    #4 rst_n_in = 1'b1;
    mdl_edge(1'b0, '0, '0);

    // Single word, one bit per clock.
    step(1'b1, 8'hD0, 16'd0);
    repeat (12) step(1'b0, 8'h00, 16'd0);
    // Four-cycle bits.
    step(1'b1, 8'hA5, 16'd3);
    repeat (36) step(1'b0, 8'h00, 16'd3);
    // Chained words with valid held high.
    step(1'b1, 8'hFF, 16'd0);
    repeat (2) step(1'b1, 8'h00, 16'd0);
    repeat (20) step(1'b0, 8'h00, 16'd0);
    // Reset in the middle of a word.
    step(1'b1, 8'hFF, 16'd0);
    repeat (4) step(1'b0, 8'h00, 16'd0);
    pulse_reset(16'd0);
    repeat (12) step(1'b0, 8'h00, 16'd0);
    // Divider changed mid-word only affects the next word.
    step(1'b1, 8'h3C, 16'd5);
    repeat (2) step(1'b1, 8'h5A, 16'd5);
    repeat (16) step(1'b0, 8'h00, 16'd5);
    repeat (50) step(1'b0, 8'h00, 16'd1);

    // Random traffic, divider churn and occasional resets.
    dv = 16'd0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) dv = VW'($urandom_range(0, 3));
      if ($urandom_range(0, 399) == 0) pulse_reset(dv);
      else step($urandom_range(0, 3) != 0, DW'($urandom), dv);
    end
    repeat (40) step(1'b0, 8'h00, dv);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
